// File: rtl/data_mem_arbiter.sv
// Two-requester data-memory arbiter: round-robin with optional ownership lock,
// one-cycle memory strobes and a registered read-return slot per access.
module data_mem_arbiter #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int MAX_LOCK = 4
) (
  input  logic              clk,
  input  logic              init,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic              lock0,
  input  logic              lock1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_r_en,
  output logic              mem_w_en,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [3:0] LP_MAX_LOCK = 4'(MAX_LOCK);

  logic              r_owner_vld;
  logic              r_owner;
  logic [3:0]        r_lock_cnt;
  logic              r_last;
  logic              r_s1_vld;
  logic              r_s1_we;
  logic              r_s1_id;
  logic [ADDR_W-1:0] r_s1_addr;
  logic [DATA_W-1:0] r_s1_wdata;
  logic              r_s2_vld;
  logic              r_s2_id;

  logic [1:0]        w_req;
  logic [1:0]        w_gnt;
  logic              w_owner_req;
  logic              w_other_req;
  logic              w_force;
  logic              w_acc;
  logic              w_acc_id;
  logic              w_acc_we;
  logic              w_acc_lock;
  logic              w_acc_other_req;
  logic [ADDR_W-1:0] w_acc_addr;
  logic [DATA_W-1:0] w_acc_wdata;
  logic [1:0]        w_rvalid;
  logic [DATA_W-1:0] w_rdata [2];

  assign w_req = {req1, req0};

  // An owner that drops its request loses ownership immediately, so the other side may win this cycle.
  assign w_owner_req = r_owner_vld && w_req[r_owner];
  assign w_other_req = w_req[~r_owner];
  assign w_force     = w_owner_req && w_other_req && (r_lock_cnt == LP_MAX_LOCK);

  always_comb begin
    w_gnt = 2'b00;
    if (!init) begin
      if (w_force)
        w_gnt[~r_owner] = 1'b1;
      else if (w_owner_req)
        w_gnt[r_owner] = 1'b1;
      else if (&w_req)
        w_gnt[~r_last] = 1'b1;
      else
        w_gnt = w_req;
    end
  end

  assign w_acc           = |w_gnt;
  assign w_acc_id        = w_gnt[1];
  assign w_acc_we        = w_acc_id ? we1    : we0;
  assign w_acc_lock      = w_acc_id ? lock1  : lock0;
  assign w_acc_addr      = w_acc_id ? addr1  : addr0;
  assign w_acc_wdata     = w_acc_id ? wdata1 : wdata0;
  assign w_acc_other_req = w_req[~w_acc_id];

  always_ff @(posedge clk) begin
    if (init) begin
      r_owner_vld <= 1'b0;
      r_owner     <= 1'b0;
      r_lock_cnt  <= '0;
      r_last      <= 1'b1;
      r_s1_vld    <= 1'b0;
      r_s1_we     <= 1'b0;
      r_s1_id     <= 1'b0;
      r_s1_addr   <= '0;
      r_s1_wdata  <= '0;
      r_s2_vld    <= 1'b0;
      r_s2_id     <= 1'b0;
    end else begin
      r_s1_vld <= w_acc;
      if (w_acc) begin
        r_s1_we    <= w_acc_we;
        r_s1_id    <= w_acc_id;
        r_s1_addr  <= w_acc_addr;
        r_s1_wdata <= w_acc_wdata;
      end
      r_s2_vld <= r_s1_vld && !r_s1_we;
      r_s2_id  <= r_s1_id;

      if (w_acc) begin
        r_last <= w_acc_id;
        if (w_acc_lock) begin
          r_owner_vld <= 1'b1;
          r_owner     <= w_acc_id;
          // Only a continuing owner accumulates; acquiring ownership starts from zero.
          if (w_owner_req && (r_owner == w_acc_id))
            r_lock_cnt <= r_lock_cnt + {3'b000, w_acc_other_req};
          else
            r_lock_cnt <= '0;
        end else begin
          r_owner_vld <= 1'b0;
          r_lock_cnt  <= '0;
        end
      end else if (r_owner_vld && !w_owner_req) begin
        r_owner_vld <= 1'b0;
        r_lock_cnt  <= '0;
      end
    end
  end

  assign gnt0      = w_gnt[0];
  assign gnt1      = w_gnt[1];
  assign mem_r_en  = r_s1_vld && !r_s1_we && !init;
  assign mem_w_en  = r_s1_vld &&  r_s1_we && !init;
  assign mem_addr  = init ? '0 : r_s1_addr;
  assign mem_wdata = init ? '0 : r_s1_wdata;

  for (genvar gi = 0; gi < 2; gi++) begin : g_rd_ret
    assign w_rvalid[gi] = r_s2_vld && (r_s2_id == 1'(gi)) && !init;
    assign w_rdata[gi]  = w_rvalid[gi] ? mem_rdata : '0;
  end

  assign rvalid0 = w_rvalid[0];
  assign rvalid1 = w_rvalid[1];
  assign rdata0  = w_rdata[0];
  assign rdata1  = w_rdata[1];

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: directed grant expectations plus a scoreboard
// of memory strobes and read returns checked every cycle.
module tb_data_mem_arbiter;

  logic       clk = 1'b0;
  logic       init = 1'b1;
  logic       req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0, lock0 = 1'b0, lock1 = 1'b0;
  logic [7:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
  logic       gnt0, gnt1, rvalid0, rvalid1, mem_r_en, mem_w_en;
  logic [7:0] rdata0, rdata1, mem_addr, mem_wdata;
  logic [7:0] mem_rdata = '0;

  typedef struct { logic we; logic [7:0] addr; logic [7:0] wdata; int due; } mem_exp_t;
  typedef struct { logic id; logic [7:0] data; int due; } rd_exp_t;

  mem_exp_t mem_q[$];
  rd_exp_t  rd_q[$];
  int       cyc = 0;
  int       n_checks = 0;
  int       n_fail = 0;
  bit       mon_en = 1'b0;

  data_mem_arbiter #(.ADDR_W(8), .DATA_W(8), .MAX_LOCK(4)) dut (
    .clk(clk), .init(init),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1), .lock0(lock0), .lock1(lock1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: read data is a fixed function of the address, returned a cycle after mem_r_en.
  always @(posedge clk) if (mem_r_en) mem_rdata <= mem_addr ^ 8'hB7;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic push_acc(input logic id, input logic we, input logic [7:0] a, input logic [7:0] d);
    mem_q.push_back('{we, a, d, cyc + 1});
    if (!we) rd_q.push_back('{id, a ^ 8'hB7, cyc + 2});
  endtask

  // c0/c1 = {req, we, lock}; eg = expected {gnt1, gnt0}
  task automatic step(input string tag,
                      input logic [2:0] c0, input logic [7:0] a0, input logic [7:0] d0,
                      input logic [2:0] c1, input logic [7:0] a1, input logic [7:0] d1,
                      input logic [1:0] eg);
    @(posedge clk); #1;
    {req0, we0, lock0} = c0; addr0 = a0; wdata0 = d0;
    {req1, we1, lock1} = c1; addr1 = a1; wdata1 = d1;
    #2;
    check_eq({tag, " gnt"}, {30'b0, gnt1, gnt0}, {30'b0, eg});
    $display("cyc %0d %s: req=%b%b gnt=%b%b exp=%b", cyc, tag, req1, req0, gnt1, gnt0, eg);
    if (eg[0]) push_acc(1'b0, c0[1], a0, d0);
    if (eg[1]) push_acc(1'b1, c1[1], a1, d1);
  endtask

  task automatic idle(input int n);
    repeat (n) step("idle", 3'b000, 8'h00, 8'h00, 3'b000, 8'h00, 8'h00, 2'b00);
  endtask

  task automatic do_reset(input int n);
    @(posedge clk); #1;
    init = 1'b1;
    {req0, we0, lock0} = 3'b100;
    {req1, we1, lock1} = 3'b000;
    mem_q.delete();
    rd_q.delete();
    repeat (n) begin
      @(posedge clk); #3;
      check_eq("rst gnt", {30'b0, gnt1, gnt0}, 32'h0);
      check_eq("rst strobes", {28'b0, mem_w_en, mem_r_en, rvalid1, rvalid0}, 32'h0);
      check_eq("rst mem bus", {16'b0, mem_addr, mem_wdata}, 32'h0);
      check_eq("rst rdata", {16'b0, rdata1, rdata0}, 32'h0);
      $display("cyc %0d reset held", cyc);
    end
    @(posedge clk); #1;
    init = 1'b0;
    req0 = 1'b0;
  endtask

  always @(negedge clk) begin
    mem_exp_t me;
    rd_exp_t  re;
    if (mon_en) begin
      if (mem_q.size() != 0 && mem_q[0].due == cyc) begin
        me = mem_q.pop_front();
        check_eq("mem strobe", {30'b0, mem_w_en, mem_r_en}, {30'b0, me.we, !me.we});
        check_eq("mem addr", {24'b0, mem_addr}, {24'b0, me.addr});
        if (me.we) check_eq("mem wdata", {24'b0, mem_wdata}, {24'b0, me.wdata});
        $display("cyc %0d mem tx we=%b addr=%h wdata=%h", cyc, mem_w_en, mem_addr, mem_wdata);
      end else begin
        check_eq("mem idle", {30'b0, mem_w_en, mem_r_en}, 32'h0);
      end
      if (rd_q.size() != 0 && rd_q[0].due == cyc) begin
        re = rd_q.pop_front();
        check_eq("rvalid", {30'b0, rvalid1, rvalid0}, re.id ? 32'h2 : 32'h1);
        check_eq("rdata", {24'b0, re.id ? rdata1 : rdata0}, {24'b0, re.data});
        $display("cyc %0d read return id=%0d data=%h", cyc, re.id, re.id ? rdata1 : rdata0);
      end else begin
        check_eq("rvalid idle", {30'b0, rvalid1, rvalid0}, 32'h0);
      end
    end
  end

  initial begin
    do_reset(2);
    mon_en = 1'b1;

    // Single read from requester 0: 0x12 returns 0xA5
    step("read0", 3'b100, 8'h12, 8'h00, 3'b000, 8'h00, 8'h00, 2'b01);
    idle(3);

    // Single write from requester 1
    step("write1", 3'b000, 8'h00, 8'h00, 3'b110, 8'h3F, 8'h7E, 2'b10);
    idle(3);

    // Continuous tie: grants alternate starting with 0 (last served is 1)
    step("tie a", 3'b100, 8'h20, 8'h00, 3'b110, 8'h40, 8'h11, 2'b01);
    step("tie b", 3'b100, 8'h21, 8'h00, 3'b110, 8'h40, 8'h11, 2'b10);
    step("tie c", 3'b100, 8'h21, 8'h00, 3'b110, 8'h41, 8'h22, 2'b01);
    step("tie d", 3'b100, 8'h22, 8'h00, 3'b110, 8'h41, 8'h22, 2'b10);
    idle(3);

    // Lock then explicit release: following tie goes to requester 0
    step("lk acq", 3'b000, 8'h00, 8'h00, 3'b101, 8'h50, 8'h00, 2'b10);
    step("lk hold", 3'b100, 8'h30, 8'h00, 3'b100, 8'h51, 8'h00, 2'b10);
    step("lk tie", 3'b100, 8'h30, 8'h00, 3'b100, 8'h52, 8'h00, 2'b01);
    step("lk r1", 3'b000, 8'h00, 8'h00, 3'b100, 8'h52, 8'h00, 2'b10);
    idle(2);

    // Lock released by owner dropping req for a cycle
    step("drop acq", 3'b000, 8'h00, 8'h00, 3'b101, 8'h60, 8'h00, 2'b10);
    idle(1);
    step("drop tie", 3'b100, 8'h31, 8'h00, 3'b101, 8'h61, 8'h00, 2'b01);
    step("drop r1", 3'b000, 8'h00, 8'h00, 3'b100, 8'h61, 8'h00, 2'b10);
    idle(2);

    // Starvation guard: 4 locked accepts by 1 while 0 waits, then 0 is granted
    step("sv acq", 3'b000, 8'h00, 8'h00, 3'b101, 8'h70, 8'h00, 2'b10);
    for (int i = 0; i < 4; i++)
      step("sv own", 3'b100, 8'h33, 8'h00, 3'b101, 8'(8'h71 + i), 8'h00, 2'b10);
    step("sv force", 3'b100, 8'h33, 8'h00, 3'b101, 8'h75, 8'h00, 2'b01);
    step("sv after", 3'b000, 8'h00, 8'h00, 3'b100, 8'h75, 8'h00, 2'b10);
    idle(3);

    // Reset during an in-flight read: nothing must emerge
    step("rst rd", 3'b100, 8'h55, 8'h00, 3'b000, 8'h00, 8'h00, 2'b01);
    do_reset(2);
    idle(3);

    // First tie after reset goes to requester 0
    step("post tie", 3'b100, 8'h0A, 8'h00, 3'b100, 8'h0B, 8'h00, 2'b01);
    step("post r1", 3'b000, 8'h00, 8'h00, 3'b100, 8'h0B, 8'h00, 2'b10);
    idle(4);

    check_eq("drain", mem_q.size() + rd_q.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
